// File: rtl/fb_pkg.sv
// Frame-buffer geometry and VGA 640x480@60 timing, shared by rasterizer, scan-out and top level.
// Constants and types only: no latency, no flow control.
// Also holds the colour-bar index helper used by the optional test pattern.
package fb_pkg;

    localparam int FB_W      = 320;
    localparam int FB_H      = 240;
    localparam int FB_ADDR_W = 17;
    localparam int FB_DEPTH  = FB_W * FB_H;

    typedef logic [11:0] rgb444_t;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    // Eight equal bars across the active width; bar_w is a build-time constant.
    function automatic logic [2:0] bar_of(input int h, input int bar_w);
        logic [2:0] idx;
        idx = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (h >= k * bar_w) idx = 3'(k);
        end
        return idx;
    endfunction

endpackage

// File: rtl/fb_scanout_if.sv
// Frame-buffer read port: address out, synchronous-read data back one clock later.
// Latency: data follows the address by exactly one clock.
// No backpressure: the BRAM port accepts a read every clock.
interface fb_scanout_if;
    import fb_pkg::*;

    logic [FB_ADDR_W-1:0] fb_r_addr;
    rgb444_t              fb_r_data;

    modport master (output fb_r_addr, input fb_r_data);
    modport slave  (input fb_r_addr, output fb_r_data);

endinterface

// File: rtl/fb_scanout_timing.sv
// VGA raster timing: pixel-tick divider, h/v counters, raw syncs, active/vblank, frame_start.
// Latency: combinational decode of the registered counters; frame_start coincides with the (0,0) tick.
// No backpressure; enable low parks divider and counters at zero.
module vga_timing_gen
    import fb_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    localparam int HW = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
    localparam int VW = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable_i,
    output logic          tick_o,
    output logic [HW-1:0] h_o,
    output logic [VW-1:0] v_o,
    output logic          hsync_o,
    output logic          vsync_o,
    output logic          active_o,
    output logic          vblank_o,
    output logic          frame_start_o
);

    localparam int DW = $clog2(CLK_DIV);

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0] H_LAST   = HW'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [DW-1:0] div_q, div_d;
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic          tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
            h_q   <= '0;
            v_q   <= '0;
        end else begin
            div_q <= div_d;
            h_q   <= h_d;
            v_q   <= v_d;
        end
    end

    always_comb begin
        tick  = enable_i && (div_q == DIV_LAST);
        div_d = div_q + 1'b1;
        h_d   = h_q;
        v_d   = v_q;
        if (!enable_i) begin
            div_d = '0;
            h_d   = '0;
            v_d   = '0;
        end else if (tick) begin
            div_d = '0;
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end
    end

    assign tick_o        = tick;
    assign h_o           = h_q;
    assign v_o           = v_q;
    assign hsync_o       = !((h_q >= HS_BEG) && (h_q <= HS_END));
    assign vsync_o       = !((v_q >= VS_BEG) && (v_q <= VS_END));
    assign active_o      = (h_q < H_ACT) && (v_q < V_ACT);
    assign vblank_o      = (v_q >= V_ACT);
    assign frame_start_o = tick && (h_q == '0) && (v_q == '0);

endmodule

// File: rtl/fb_scanout.sv
// Y-flipped 2x2 pixel-doubled scan-out of the frame buffer to 4-bit VGA; FB_SCANOUT_PATTERN_EN adds colour bars.
// Latency: address registered on the pixel tick, colour/syncs/vblank one pixel tick later; frame_start undelayed.
// No backpressure: one BRAM read per pixel tick; enable low blanks and parks the raster at (0,0).
module fb_scanout
    import fb_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_enable,
`ifdef FB_SCANOUT_PATTERN_EN
    input  logic         i_pattern,
`endif
    fb_scanout_if.master fb_rd,
    output logic [3:0]   o_vga_r,
    output logic [3:0]   o_vga_g,
    output logic [3:0]   o_vga_b,
    output logic         o_hsync,
    output logic         o_vsync,
    output logic         o_vblank,
    output logic         o_frame_start
);

    localparam int HW      = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam int VW      = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam int FB_COLS = H_ACTIVE / 2;
    localparam int FB_ROWS = V_ACTIVE / 2;

    localparam logic [FB_ADDR_W-1:0] ROW_TOP    = FB_ADDR_W'((FB_ROWS - 1) * FB_COLS);
    localparam logic [FB_ADDR_W-1:0] ROW_STEP   = FB_ADDR_W'(FB_COLS);
    localparam logic [HW-1:0]        H_LAST     = HW'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [VW-1:0]        V_LAST     = VW'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [VW-1:0]        V_ACT_LAST = VW'(V_ACTIVE - 1);

    logic          tick, hs_raw, vs_raw, act_raw, vb_raw, frame_start;
    logic [HW-1:0] h;
    logic [VW-1:0] v;

    vga_timing_gen #(
        .CLK_DIV  (CLK_DIV),
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable_i      (i_enable),
        .tick_o        (tick),
        .h_o           (h),
        .v_o           (v),
        .hsync_o       (hs_raw),
        .vsync_o       (vs_raw),
        .active_o      (act_raw),
        .vblank_o      (vb_raw),
        .frame_start_o (frame_start)
    );

    logic [FB_ADDR_W-1:0] addr_q, addr_d;
    logic [FB_ADDR_W-1:0] row_q, row_d;
    logic                 act0_q, act0_d, hs0_q, hs0_d, vs0_q, vs0_d, vb0_q, vb0_d;
    rgb444_t              rgb_q, rgb_d;
    logic                 hs_q, hs_d, vs_q, vs_d, vb_q, vb_d;
`ifdef FB_SCANOUT_PATTERN_EN
    logic [2:0]           bar0_q, bar0_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            row_q  <= ROW_TOP;
            act0_q <= 1'b0;
            hs0_q  <= 1'b1;
            vs0_q  <= 1'b1;
            vb0_q  <= 1'b0;
            rgb_q  <= '0;
            hs_q   <= 1'b1;
            vs_q   <= 1'b1;
            vb_q   <= 1'b0;
        end else begin
            addr_q <= addr_d;
            row_q  <= row_d;
            act0_q <= act0_d;
            hs0_q  <= hs0_d;
            vs0_q  <= vs0_d;
            vb0_q  <= vb0_d;
            rgb_q  <= rgb_d;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
            vb_q   <= vb_d;
        end
    end

`ifdef FB_SCANOUT_PATTERN_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bar0_q <= '0;
        else        bar0_q <= bar0_d;
    end
`endif

    always_comb begin
        addr_d = addr_q;
        row_d  = row_q;
        act0_d = act0_q;
        hs0_d  = hs0_q;
        vs0_d  = vs0_q;
        vb0_d  = vb0_q;
        rgb_d  = rgb_q;
        hs_d   = hs_q;
        vs_d   = vs_q;
        vb_d   = vb_q;
`ifdef FB_SCANOUT_PATTERN_EN
        bar0_d = bar0_q;
`endif
        if (!i_enable) begin
            // Address is left alone so the BRAM port stays quiet while parked.
            row_d  = ROW_TOP;
            act0_d = 1'b0;
            hs0_d  = 1'b1;
            vs0_d  = 1'b1;
            vb0_d  = 1'b0;
            rgb_d  = '0;
            hs_d   = 1'b1;
            vs_d   = 1'b1;
            vb_d   = 1'b0;
        end else if (tick) begin
            if (act_raw) addr_d = row_q + FB_ADDR_W'(h[HW-1:1]);
            // Row base walks down one FB row every second active line; the last line never steps below zero.
            if (h == H_LAST) begin
                if (v == V_LAST)                 row_d = ROW_TOP;
                else if (v[0] && v < V_ACT_LAST) row_d = row_q - ROW_STEP;
            end
            act0_d = act_raw;
            hs0_d  = hs_raw;
            vs0_d  = vs_raw;
            vb0_d  = vb_raw;
`ifdef FB_SCANOUT_PATTERN_EN
            bar0_d = bar_of(int'(h), H_ACTIVE / 8);
`endif
            rgb_d  = act0_q ? fb_rd.fb_r_data : '0;
`ifdef FB_SCANOUT_PATTERN_EN
            if (act0_q && i_pattern) rgb_d = {{4{bar0_q[2]}}, {4{bar0_q[1]}}, {4{bar0_q[0]}}};
`endif
            hs_d   = hs0_q;
            vs_d   = vs0_q;
            vb_d   = vb0_q;
        end
    end

    assign fb_rd.fb_r_addr = addr_q;
    assign o_vga_r         = rgb_q[11:8];
    assign o_vga_g         = rgb_q[7:4];
    assign o_vga_b         = rgb_q[3:0];
    assign o_hsync         = hs_q;
    assign o_vsync         = vs_q;
    assign o_vblank        = vb_q;
    assign o_frame_start   = frame_start;

endmodule

// File: tb/tb_fb_scanout.sv
// Directed bench: full-size scan-out for the first lines, plus a shrunken raster for whole-frame timing.
module tb_fb_scanout;

    logic clk = 1'b0;
    logic rst_n, en_d, en_s;
    always #5 clk = ~clk;

    fb_scanout_if bus_d ();
    fb_scanout_if bus_s ();

    logic [3:0] d_r, d_g, d_b, s_r, s_g, s_b;
    logic       d_hs, d_vs, d_vb, d_fs, s_hs, s_vs, s_vb, s_fs;
`ifdef FB_SCANOUT_PATTERN_EN
    logic       pat;
`endif

    fb_scanout u_dut (
        .clk (clk), .rst_n (rst_n), .i_enable (en_d),
`ifdef FB_SCANOUT_PATTERN_EN
        .i_pattern (pat),
`endif
        .fb_rd (bus_d),
        .o_vga_r (d_r), .o_vga_g (d_g), .o_vga_b (d_b),
        .o_hsync (d_hs), .o_vsync (d_vs), .o_vblank (d_vb), .o_frame_start (d_fs)
    );

    // 24x17 raster, FB 8x6, two clocks per pixel: a whole frame is 816 clocks.
    fb_scanout #(
        .CLK_DIV (2), .H_ACTIVE (16), .H_FP (2), .H_SYNC (3), .H_BP (3),
        .V_ACTIVE (12), .V_FP (1), .V_SYNC (2), .V_BP (2)
    ) u_small (
        .clk (clk), .rst_n (rst_n), .i_enable (en_s),
`ifdef FB_SCANOUT_PATTERN_EN
        .i_pattern (1'b0),
`endif
        .fb_rd (bus_s),
        .o_vga_r (s_r), .o_vga_g (s_g), .o_vga_b (s_b),
        .o_hsync (s_hs), .o_vsync (s_vs), .o_vblank (s_vb), .o_frame_start (s_fs)
    );

    // Frame-buffer model: one-clock synchronous read returning the low 12 address bits.
    always @(posedge clk) begin
        bus_d.fb_r_data <= bus_d.fb_r_addr[11:0];
        bus_s.fb_r_data <= bus_s.fb_r_addr[11:0];
    end

    int checks = 0;
    int fails  = 0;
    int now_clk = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        now_clk += n;
        #1;
    endtask

    // Sampled just after the pixel tick at (h,v): address for (h,v), colour/syncs for the previous tick.
    typedef struct {
        int h;
        int v;
        int addr;
        int rgb;
        int hs;
    } vec_t;

    vec_t tbl[19];

    initial begin
        int hs_lo, vs_lo, vb_hi, fs_cnt, fs_at, nz, amax, amin;

        tbl[0]  = '{0,   0, 76480, 'h000, 1};
        tbl[1]  = '{1,   0, 76480, 'hAC0, 1};
        tbl[2]  = '{2,   0, 76481, 'hAC0, 1};
        tbl[3]  = '{3,   0, 76481, 'hAC1, 1};
        tbl[4]  = '{4,   0, 76482, 'hAC1, 1};
        tbl[5]  = '{639, 0, 76799, 'hBFF, 1};
        tbl[6]  = '{640, 0, 76799, 'hBFF, 1};
        tbl[7]  = '{641, 0, 76799, 'h000, 1};
        tbl[8]  = '{656, 0, 76799, 'h000, 1};
        tbl[9]  = '{657, 0, 76799, 'h000, 0};
        tbl[10] = '{752, 0, 76799, 'h000, 0};
        tbl[11] = '{753, 0, 76799, 'h000, 1};
        tbl[12] = '{0,   1, 76480, 'h000, 1};
        tbl[13] = '{1,   1, 76480, 'hAC0, 1};
        tbl[14] = '{1,   2, 76160, 'h980, 1};
        tbl[15] = '{2,   2, 76161, 'h980, 1};
        tbl[16] = '{3,   2, 76161, 'h981, 1};
        tbl[17] = '{1,   3, 76160, 'h980, 1};
        tbl[18] = '{300, 3, 76310, 'hA15, 1};

        rst_n = 1'b1;
        en_d  = 1'b0;
        en_s  = 1'b0;
`ifdef FB_SCANOUT_PATTERN_EN
        pat   = 1'b0;
`endif
        #2 rst_n = 1'b0;
        step(3);
        chk("rst_addr",  int'(bus_d.fb_r_addr), 0);
        chk("rst_rgb",   int'({d_r, d_g, d_b}), 0);
        chk("rst_hsync", int'(d_hs), 1);
        chk("rst_vsync", int'(d_vs), 1);
        chk("rst_vblank", int'(d_vb), 0);
        chk("rst_fs",    int'(d_fs), 0);

        rst_n = 1'b1;
        step(2);
        en_d = 1'b1;
        now_clk = 0;
        step(2);
        chk("fs_early", int'(d_fs), 0);
        step(1);
        chk("fs_4th_clk", int'(d_fs), 1);

        for (int i = 0; i < 19; i++) begin
            step(4 * (tbl[i].v * 800 + tbl[i].h + 1) - now_clk);
            chk($sformatf("addr[%0d]", i),  int'(bus_d.fb_r_addr), tbl[i].addr);
            chk($sformatf("rgb[%0d]", i),   int'({d_r, d_g, d_b}), tbl[i].rgb);
            chk($sformatf("hsync[%0d]", i), int'(d_hs), tbl[i].hs);
            chk($sformatf("vsync[%0d]", i), int'(d_vs), 1);
            chk($sformatf("vblank[%0d]", i), int'(d_vb), 0);
        end

        // Drop enable mid-line: blank on the next clock, address held.
        en_d = 1'b0;
        step(1);
        chk("off_addr",  int'(bus_d.fb_r_addr), 76310);
        chk("off_rgb",   int'({d_r, d_g, d_b}), 0);
        chk("off_hsync", int'(d_hs), 1);
        chk("off_vsync", int'(d_vs), 1);
        chk("off_fs",    int'(d_fs), 0);
        step(5);

        en_d = 1'b1;
        now_clk = 0;
        step(3);
        chk("restart_fs",   int'(d_fs), 1);
        step(1);
        chk("restart_addr", int'(bus_d.fb_r_addr), 76480);
        step(4);
        chk("restart_rgb",  int'({d_r, d_g, d_b}), 'hAC0);

        // One full line: 96 sync ticks and 640 visible (never-zero) ticks.
        hs_lo = 0;
        nz    = 0;
        for (int i = 0; i < 3200; i++) begin
            step(1);
            if (!d_hs) hs_lo++;
            if ({d_r, d_g, d_b} != 12'h000) nz++;
        end
        chk("line_hsync_low_clks", hs_lo, 384);
        chk("line_visible_clks",   nz, 2560);

        // Asynchronous reset mid-line, checked before any further clock edge.
        rst_n = 1'b0;
        #2;
        chk("arst_addr",  int'(bus_d.fb_r_addr), 0);
        chk("arst_rgb",   int'({d_r, d_g, d_b}), 0);
        chk("arst_hsync", int'(d_hs), 1);
        en_d = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);

        en_s = 1'b1;
        now_clk = 0;
        step(560);
        chk("s_last_addr", int'(bus_s.fb_r_addr), 7);
        step(2);
        chk("s_last_rgb",  int'({s_r, s_g, s_b}), 'h007);

        hs_lo = 0; vs_lo = 0; vb_hi = 0; fs_cnt = 0; fs_at = -1;
        amax = -1; amin = 1 << 20;
        for (int i = 0; i < 816; i++) begin
            step(1);
            if (!s_hs) hs_lo++;
            if (!s_vs) vs_lo++;
            if (s_vb)  vb_hi++;
            if (s_fs) begin
                fs_cnt++;
                fs_at = now_clk;
            end
            if (int'(bus_s.fb_r_addr) > amax) amax = int'(bus_s.fb_r_addr);
            if (int'(bus_s.fb_r_addr) < amin) amin = int'(bus_s.fb_r_addr);
        end
        chk("s_fs_count",      fs_cnt, 1);
        chk("s_frame_period",  fs_at, 817);
        chk("s_hsync_low",     hs_lo, 102);
        chk("s_vsync_low",     vs_lo, 96);
        chk("s_vblank_high",   vb_hi, 240);
        chk("s_addr_max",      amax, 47);
        chk("s_addr_min",      amin, 0);

`ifdef FB_SCANOUT_PATTERN_EN
        pat  = 1'b1;
        en_d = 1'b1;
        now_clk = 0;
        step(8);
        chk("pat_h0",   int'({d_r, d_g, d_b}), 'h000);
        step(328 - now_clk);
        chk("pat_h80",  int'({d_r, d_g, d_b}), 'h00F);
        step(2248 - now_clk);
        chk("pat_h560", int'({d_r, d_g, d_b}), 'hFFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
